mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage_pkg.sv | 32 +++
 rtl/pipe_reg.sv | 26 ++
 rtl/mem_stage.sv | 161 ++++++++++++++++
 tb/tb_mem_stage.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM pipeline stage: FSM encoding, timeout
// default and the packed layouts of the EX/MEM and MEM/WB registers.
package mem_stage_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_FAULT = 2'd2
  } mem_state_e;

  localparam int TIMEOUT_DEFAULT = 16;
  localparam int CNT_W           = 4;

  typedef struct packed {
    logic        valid;
    logic [15:0] alu_res;
    logic [15:0] rt;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic        reg_write;
    logic [2:0]  write_reg;
  } exmem_t;

  typedef struct packed {
    logic        valid;
    logic [15:0] write_back;
    logic        reg_write;
    logic [2:0]  write_reg;
  } memwb_t;

endpackage

// File: rtl/pipe_reg.sv
// Generic pipeline register: loads d_i when en_i is high, clears
// asynchronously on rst_n low.
module pipe_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] data_q;

  // Enabled capture with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else if (en_i) begin
      data_q <= d_i;
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: EX/MEM register, data-memory request FSM with
// timeout fault, and MEM/WB register feeding writeback and forwarding.
//
// Memory handshake: mem_req is held high for the whole WAIT state with
// mem_wr/mem_addr/mem_wdata stable; the access completes on the rising
// edge where mem_ack is 1. mem_ack is ignored whenever mem_req is 0.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  input  logic [15:0] ex_ALURes,
  input  logic [15:0] ex_rt,
  input  logic        ex_memRead,
  input  logic        ex_memWrite,
  input  logic        ex_memToReg,
  input  logic        ex_regWrite,
  input  logic [2:0]  ex_writeReg,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack,
  output logic        stall,
  output logic [15:0] exmem_ALURes,
  output logic [2:0]  exmem_writeReg,
  output logic        exmem_regWrite,
  output logic        exmem_memRead,
  output logic        memwb_valid,
  output logic [15:0] memwb_writeBack,
  output logic [2:0]  memwb_writeReg,
  output logic        memwb_regWrite,
  output logic        err,
  output mem_state_e  dbg_state_o
);

  mem_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  exmem_t           exmem_d, exmem_q;
  memwb_t           memwb_d, memwb_q;

  logic in_wait, load_ex, ex_is_mem, ex_starts_wait, ex_misaligned;
  logic timeout_hit, exmem_misaligned;

  assign in_wait        = (state_q == S_WAIT);
  assign stall          = (in_wait && !mem_ack) || (state_q == S_FAULT);
  assign load_ex        = !stall;
  assign ex_is_mem      = ex_valid && (ex_memRead || ex_memWrite);
  // Odd addresses never reach memory; they only raise err.
  assign ex_starts_wait = load_ex && ex_is_mem && !ex_ALURes[0];
  assign ex_misaligned  = load_ex && ex_is_mem && ex_ALURes[0];
  assign timeout_hit    = in_wait && !mem_ack && (cnt_q == CNT_W'(TIMEOUT - 1));
  assign exmem_misaligned = exmem_q.valid && (exmem_q.mem_read || exmem_q.mem_write)
                            && exmem_q.alu_res[0];

  // Pack the EX inputs into the EX/MEM register image.
  always_comb begin
    exmem_d            = '0;
    exmem_d.valid      = ex_valid;
    exmem_d.alu_res    = ex_ALURes;
    exmem_d.rt         = ex_rt;
    exmem_d.mem_read   = ex_memRead;
    exmem_d.mem_write  = ex_memWrite;
    exmem_d.mem_to_reg = ex_memToReg;
    exmem_d.reg_write  = ex_regWrite;
    exmem_d.write_reg  = ex_writeReg;
  end

  pipe_reg #(.W($bits(exmem_t))) u_exmem (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (load_ex),
    .d_i   (exmem_d),
    .q_o   (exmem_q)
  );

  // Next state, wait counter and sticky error.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q | ex_misaligned;
    unique case (state_q)
      S_IDLE: begin
        if (ex_starts_wait) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end
      end
      S_WAIT: begin
        if (mem_ack) begin
          state_d = ex_starts_wait ? S_WAIT : S_IDLE;
          cnt_d   = '0;
        end else if (timeout_hit) begin
          state_d = S_FAULT;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM, counter and error registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // MEM/WB image: a bubble whenever stalled or the access was misaligned.
  always_comb begin
    memwb_d = '0;
    if (!stall && exmem_q.valid && !exmem_misaligned) begin
      memwb_d.valid      = 1'b1;
      memwb_d.write_back = (exmem_q.mem_read && exmem_q.mem_to_reg) ? mem_rdata
                                                                    : exmem_q.alu_res;
      memwb_d.reg_write  = exmem_q.reg_write;
      memwb_d.write_reg  = exmem_q.write_reg;
    end
  end

  pipe_reg #(.W($bits(memwb_t))) u_memwb (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (1'b1),
    .d_i   (memwb_d),
    .q_o   (memwb_q)
  );

  assign mem_req   = in_wait;
  assign mem_wr    = in_wait && exmem_q.mem_write;
  assign mem_addr  = in_wait ? exmem_q.alu_res : 16'h0000;
  assign mem_wdata = in_wait ? exmem_q.rt      : 16'h0000;

  assign exmem_ALURes   = exmem_q.alu_res;
  assign exmem_writeReg = exmem_q.write_reg;
  assign exmem_regWrite = exmem_q.valid && exmem_q.reg_write;
  assign exmem_memRead  = exmem_q.valid && exmem_q.mem_read;

  assign memwb_valid     = memwb_q.valid;
  assign memwb_writeBack = memwb_q.write_back;
  assign memwb_writeReg  = memwb_q.write_reg;
  assign memwb_regWrite  = memwb_q.valid && memwb_q.reg_write;

  assign err         = err_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: instruction-level reference model with a memory
// responder of chosen latency, retirement scoreboard and request checker.
module tb_mem_stage;
  import mem_stage_pkg::*;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_valid, ex_memRead, ex_memWrite, ex_memToReg, ex_regWrite;
  logic [15:0] ex_ALURes, ex_rt, mem_rdata, mem_addr, mem_wdata;
  logic [15:0] exmem_ALURes, memwb_writeBack;
  logic [2:0]  ex_writeReg, exmem_writeReg, memwb_writeReg;
  logic        mem_req, mem_wr, mem_ack, stall, exmem_regWrite, exmem_memRead;
  logic        memwb_valid, memwb_regWrite, err;
  mem_state_e  dbg_state;

  mem_stage #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_ALURes(ex_ALURes),
    .ex_rt(ex_rt), .ex_memRead(ex_memRead), .ex_memWrite(ex_memWrite),
    .ex_memToReg(ex_memToReg), .ex_regWrite(ex_regWrite), .ex_writeReg(ex_writeReg),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .stall(stall),
    .exmem_ALURes(exmem_ALURes), .exmem_writeReg(exmem_writeReg),
    .exmem_regWrite(exmem_regWrite), .exmem_memRead(exmem_memRead),
    .memwb_valid(memwb_valid), .memwb_writeBack(memwb_writeBack),
    .memwb_writeReg(memwb_writeReg), .memwb_regWrite(memwb_regWrite),
    .err(err), .dbg_state_o(dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [15:0] alu;
    logic [15:0] rt;
    logic        rd, wr, m2r, rw;
    logic [2:0]  wreg;
    int          lat;
    logic [15:0] rdata;
  } instr_t;

  typedef struct {
    logic [15:0] addr, wdata, rdata;
    logic        wr;
    int          lat;
  } req_t;

  instr_t      instr_q[$];
  req_t        req_q[$];
  logic [19:0] exp_q[$];   // {regWrite, writeReg, writeBack}
  int          due_q[$];   // cycle at which each exp_q entry must retire
  instr_t      cur, last;
  logic        cur_live, exp_err, exp_fault, fault_pending, force_ack;
  int          n_checks, n_fail, cyc, wait_cnt;
  int          stall_cnt, req_cnt, wr_cnt, exp_stall;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic drive(input instr_t c);
    ex_valid    = c.valid;
    ex_ALURes   = c.alu;
    ex_rt       = c.rt;
    ex_memRead  = c.rd;
    ex_memWrite = c.wr;
    ex_memToReg = c.m2r;
    ex_regWrite = c.rw;
    ex_writeReg = c.wreg;
  endtask

  function automatic instr_t mk(input logic rd, input logic wr, input logic m2r,
                                input logic rw, input logic [2:0] wreg,
                                input logic [15:0] alu, input logic [15:0] rt,
                                input int lat, input logic [15:0] rdata);
    instr_t c;
    c.valid = 1'b1; c.rd = rd; c.wr = wr; c.m2r = m2r; c.rw = rw; c.wreg = wreg;
    c.alu = alu; c.rt = rt; c.lat = lat; c.rdata = rdata;
    return c;
  endfunction

  function automatic instr_t bubble();
    instr_t c;
    c = mk(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 3'($urandom),
           16'($urandom), 16'($urandom), 0, 16'h0);
    c.valid = 1'b0;
    return c;
  endfunction

  function automatic instr_t rand_instr();
    instr_t c;
    int k;
    k = $urandom_range(0, 99);
    c = mk(1'b0, 1'b0, 1'b0, 1'($urandom), 3'($urandom), 16'($urandom),
           16'($urandom), $urandom_range(0, 4), 16'($urandom));
    if (k < 10) c = bubble();
    else if (k < 50) begin end
    else if (k < 75) begin c.rd = 1'b1; c.m2r = 1'($urandom); c.alu[0] = 1'b0; end
    else if (k < 95) begin c.wr = 1'b1; c.alu[0] = 1'b0; end
    else begin c.rd = 1'b1; c.m2r = 1'b1; c.alu[0] = 1'b1; end
    return c;
  endfunction

  // One clock cycle: present EX, respond to memory, score outputs, update model.
  task automatic step();
    @(negedge clk);
    cyc++;
    if (!cur_live) begin
      if (instr_q.size() > 0) cur = instr_q.pop_front();
      else cur = bubble();
      cur_live = 1'b1;
    end
    drive(cur);
    mem_ack   = 1'b0;
    mem_rdata = 16'($urandom);
    #1;
    if (mem_req) begin
      req_cnt++;
      if (mem_wr) wr_cnt++;
      if (exp_fault || req_q.size() == 0) begin
        check("unexpected_req", 1, 0);
      end else begin
        check("req_addr", mem_addr, req_q[0].addr);
        check("req_wr", mem_wr, req_q[0].wr);
        if (req_q[0].wr) check("req_wdata", mem_wdata, req_q[0].wdata);
        if (wait_cnt == req_q[0].lat) begin
          mem_ack   = 1'b1;
          mem_rdata = req_q[0].rdata;
          void'(req_q.pop_front());
          wait_cnt  = 0;
        end else begin
          wait_cnt++;
          if (wait_cnt == TO) fault_pending = 1'b1;
        end
      end
    end else begin
      check("mem_idle_zero", {mem_wr, mem_addr, mem_wdata}, 0);
      if (force_ack) begin
        mem_ack   = 1'b1;
        mem_rdata = 16'hDEAD;
      end
    end
    #1;
    if (stall) stall_cnt++;
    if (exp_fault || fault_pending) check("fault_stall", stall, 1);
    if (force_ack) check("ack_ignored_stall", stall, 0);
    check("err", err, exp_err);
    check("exmem_alu", exmem_ALURes, last.alu);
    check("exmem_wreg", exmem_writeReg, last.wreg);
    check("exmem_regwrite", exmem_regWrite, last.valid & last.rw);
    check("exmem_memread", exmem_memRead, last.valid & last.rd);
    if (memwb_valid) begin
      if (exp_q.size() == 0) begin
        check("spurious_retire", 1, 0);
      end else begin
        logic [19:0] e;
        int d;
        e = exp_q.pop_front();
        d = due_q.pop_front();
        check("wb_value", memwb_writeBack, e[15:0]);
        check("wb_reg", memwb_writeReg, e[18:16]);
        check("wb_regwrite", memwb_regWrite, e[19]);
        check("wb_cycle", cyc, d);
      end
    end else begin
      check("bubble_regwrite", memwb_regWrite, 0);
    end
    if (fault_pending) begin
      exp_err = 1'b1;
      exp_fault = 1'b1;
      fault_pending = 1'b0;
    end
    if (!stall) begin
      last = cur;
      cur_live = 1'b0;
      if (cur.valid && (cur.rd || cur.wr)) begin
        if (cur.alu[0]) begin
          exp_err = 1'b1;
        end else begin
          req_t r;
          r.addr = cur.alu; r.wdata = cur.rt; r.wr = cur.wr; r.lat = cur.lat; r.rdata = cur.rdata;
          req_q.push_back(r);
          exp_q.push_back({cur.rw, cur.wreg, (cur.rd && cur.m2r) ? cur.rdata : cur.alu});
          due_q.push_back(cyc + 2 + cur.lat);
          exp_stall += cur.lat;
        end
      end else if (cur.valid) begin
        exp_q.push_back({cur.rw, cur.wreg, cur.alu});
        due_q.push_back(cyc + 2);
      end
    end
  endtask

  // Asynchronous reset between clock edges; outputs must clear at once.
  task automatic do_reset();
    instr_t z;
    z = mk(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0, 16'h0, 0, 16'h0);
    z.valid = 1'b0;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("reset_mem_outputs", {mem_req, mem_wr, mem_addr, mem_wdata, stall}, 0);
    check("reset_pipe_outputs", {exmem_ALURes, exmem_writeReg, exmem_regWrite, exmem_memRead,
          memwb_valid, memwb_writeBack, memwb_writeReg, memwb_regWrite, err,
          2'(dbg_state)}, 0);
    instr_q.delete(); req_q.delete(); exp_q.delete(); due_q.delete();
    cur = z; last = z; cur_live = 1'b1; drive(z);
    mem_ack = 1'b0;
    exp_err = 1'b0; exp_fault = 1'b0; fault_pending = 1'b0; wait_cnt = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic clear_counters();
    stall_cnt = 0; req_cnt = 0; wr_cnt = 0; exp_stall = 0;
  endtask

  task automatic drain(input string tag);
    int budget;
    budget = 2000;
    while ((instr_q.size() > 0 || exp_q.size() > 0 || req_q.size() > 0 ||
            (cur_live && cur.valid)) && budget > 0) begin
      step();
      budget--;
    end
    if (budget == 0) check({tag, "_drain_timeout"}, 1, 0);
    repeat (2) step();
  endtask

  initial begin
    n_checks = 0; n_fail = 0; cyc = 0; force_ack = 1'b0;
    mem_ack = 1'b0; mem_rdata = 16'h0;
    clear_counters();
    do_reset();

    // ALU op retires one cycle after EX/MEM with no stall
    clear_counters();
    instr_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 3'd3, 16'h1234, 16'h5555, 0, 16'h0));
    drain("alu");
    check("alu_stall_cycles", stall_cnt, 0);

    // Load with three wait cycles
    clear_counters();
    instr_q.push_back(mk(1'b1, 1'b0, 1'b1, 1'b1, 3'd5, 16'h0040, 16'h0, 3, 16'hBEEF));
    drain("load");
    check("load_stall_cycles", stall_cnt, 3);
    check("load_req_cycles", req_cnt, 4);

    // Store acknowledged in its first cycle
    clear_counters();
    instr_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 3'd1, 16'h0010, 16'h00AA, 0, 16'h0));
    drain("store");
    check("store_wr_cycles", wr_cnt, 1);
    check("store_stall_cycles", stall_cnt, 0);

    // Misaligned load: no request, sticky err, bubble
    clear_counters();
    instr_q.push_back(mk(1'b1, 1'b0, 1'b1, 1'b1, 3'd2, 16'h0041, 16'h0, 0, 16'h1111));
    drain("misaligned");
    check("misaligned_req_cycles", req_cnt, 0);
    check("misaligned_err", err, 1);

    // Randomized instruction mix
    do_reset();
    clear_counters();
    for (int i = 0; i < 300; i++) instr_q.push_back(rand_instr());
    drain("random");
    check("random_stall_total", stall_cnt, exp_stall);

    // Timeout into FAULT, then reset
    do_reset();
    clear_counters();
    instr_q.push_back(mk(1'b1, 1'b0, 1'b1, 1'b1, 3'd4, 16'h0080, 16'h0, 1000, 16'h0));
    for (int i = 0; i < 5; i++) instr_q.push_back(rand_instr());
    repeat (26) step();
    check("timeout_req_cycles", req_cnt, TO);
    check("fault_err", err, 1);
    check("fault_stall_held", stall, 1);
    do_reset();

    // Reset in the middle of WAIT, then a stray ack in IDLE
    clear_counters();
    instr_q.push_back(mk(1'b1, 1'b0, 1'b1, 1'b1, 3'd6, 16'h0100, 16'h0, 1000, 16'h0));
    repeat (5) step();
    do_reset();
    clear_counters();
    force_ack = 1'b1;
    repeat (2) step();
    force_ack = 1'b0;
    repeat (2) step();
    check("stray_ack_stall_cycles", stall_cnt, 0);

    // Short random run after recovery
    clear_counters();
    for (int i = 0; i < 40; i++) instr_q.push_back(rand_instr());
    drain("post_reset");
    check("post_reset_stall_total", stall_cnt, exp_stall);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
